mdu: RTL
========

// Module: mdu
// PURPOSE
//  Multiply/divide unit in the E stage, next to the ALU. It takes the same forwarded A/B operands.
//  It owns the HI/LO registers. Its MDO read result is muxed with the ALU result into the E/M pipeline register.
//  A multi-cycle op raises Busy. Busy stalls any later MD instruction in D.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu (and madd-family); must be >= 1
//  DIV_CYCLES   10  cycles Busy stays high for div/divu; must be >= 1
// PORTS
//  clk    in   1   clock; all state updates on the rising edge
//  reset  in   1   asynchronous, active-low reset
//  Start  in   1   qualifies MDOp as a multi-cycle op (MDOp 1-4, 9-12) this cycle
//  MDOp   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-12 see CONFIGURATION
//  A      in   32  rs operand (forwarded)
//  B      in   32  rt operand (forwarded)
//  Req    in   1   exception/interrupt flush from CP0; high means the E-stage instruction is cancelled
//  Busy   out  1   multi-cycle op in flight
//  HI     out  32  HI register
//  LO     out  32  LO register
//  MDO    out  32  read result: HI for mfhi, LO for mflo, else 0 (combinational)
// BEHAVIOUR
//  Reset: while reset=0, asynchronously force state=IDLE, counter=0, Busy=0, HI=0, LO=0.
//   This includes reset mid-operation; the in-flight result is discarded.
//  FSM states: IDLE, RUN.
//   IDLE->RUN on an edge with Start=1, Busy=0, Req=0 and MDOp in a start code.
//    On that edge latch the op, latch A and B, and load counter = MULT_CYCLES or DIV_CYCLES.
//   RUN: counter decrements each edge.
//    On the edge where counter==1: write HI/LO, go to IDLE.
//  Busy = (state==RUN).
//   Busy is high for exactly N cycles after the accepting edge.
//   New HI/LO are visible on the same edge where Busy falls.
//  Start while Busy=1: ignored. Upstream must stall, so a bench asserting this is a protocol error.
//  Start with MDOp outside the start codes: ignored, no state change.
//  Req=1: blocks acceptance of Start and blocks mthi/mtlo on that edge.
//   Req does NOT abort an op already in RUN; that op belongs to an older, committed instruction.
//  mthi/mtlo (MDOp 7/8, Start not required): write A into HI/LO on the edge when Busy=0 and Req=0.
//   While Busy=1 they are ignored; the hazard unit stalls them.
//  mult:  {HI,LO} = $signed(A) * $signed(B), full 64-bit product.
//  multu: {HI,LO} = A * B, unsigned 64-bit.
//  div:   LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
//   0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  divu:  LO = A / B, HI = A % B, unsigned.
//  Divide by zero (B==0 at accept): the op still runs DIV_CYCLES cycles with Busy high; HI/LO are left unchanged.
//  The operands used are the ones latched at accept; later A/B changes do not affect the result.
//  MDO reads the current HI/LO registers, so mfhi during RUN returns the old value.
//   The hazard unit stalls mfhi/mflo while Busy or Start.
// CONFIGURATION
//  MDU_MADD_EN defined: adds the accumulate ops, using MULT_CYCLES:
//   9  madd:  {HI,LO} += signed(A*B)
//   10 maddu: {HI,LO} += unsigned(A*B)
//   11 msub:  {HI,LO} -= signed(A*B)
//   12 msubu: {HI,LO} -= unsigned(A*B)
//   Arithmetic is mod 2^64, no overflow flag.
//   The accumulate uses the {HI,LO} value at the completion edge.
//  MDU_MADD_EN undefined: MDOp 9-12 are no-ops; Start with them is ignored and Busy stays 0.
// TESTING
//  1 reset=0 mid-div (Busy=1, HI=LO=5 preloaded) -> Busy=0, HI=LO=0 immediately, with no clock edge needed.
//  2 mult A=0xFFFFFFFE(-2), B=3, Start -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  3 div A=0xFFFFFFF9(-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    divu with the same operands -> LO=0x7FFFFFFC, HI=1.
//  4 mthi A=0x1234 then mtlo A=0x5678 on idle edges -> HI=0x1234, LO=0x5678.
//    Then MDOp=5 -> MDO=0x1234; MDOp=6 -> MDO=0x5678.
//  5 Start mult with Req=1 -> Busy stays 0, HI/LO unchanged.
//    Req=1 during RUN of a divu 100/7 -> completes anyway: LO=14, HI=2.
//  6 div with B=0, HI=0xAA, LO=0xBB -> Busy high 10 cycles, HI/LO still 0xAA/0xBB.
//    With MDU_MADD_EN: preset HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: multi-cycle mult/div with Busy, mthi/mtlo writes, mfhi/mflo read mux.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (MDOp 9-12).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [3:0]    op_reg, op_next;
    logic [31:0]   a_reg, a_next;
    logic [31:0]   b_reg, b_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;

    logic          start_code;
    logic          start_is_div;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   div_a, div_b, quo, rem;
    logic [63:0]   result;
    logic          write_en;

    always_comb begin
        start_code   = 1'b0;
        start_is_div = 1'b0;
        case (MDOp)
            OP_MULT, OP_MULTU: start_code = 1'b1;
            OP_DIV, OP_DIVU: begin
                start_code   = 1'b1;
                start_is_div = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_code = 1'b1;
`endif
            default: ;
        endcase
    end

    // Products are computed on the operands latched at accept, never on live A/B.
    always_comb begin
        prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
        prod_u = {32'd0, a_reg} * {32'd0, b_reg};
    end

    // Signed division via magnitudes, so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    always_comb begin
        div_a = a_reg;
        div_b = b_reg;
        if (op_reg == OP_DIV) begin
            if (a_reg[31]) div_a = -a_reg;
            if (b_reg[31]) div_b = -b_reg;
        end
        if (b_reg == 32'd0) div_b = 32'd1;
        quo = div_a / div_b;
        rem = div_a % div_b;
        if (op_reg == OP_DIV) begin
            if (a_reg[31] ^ b_reg[31]) quo = -quo;
            if (a_reg[31]) rem = -rem;
        end
    end

    always_comb begin
        result   = {hi_reg, lo_reg};
        write_en = 1'b1;
        case (op_reg)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                result   = {rem, quo};
                write_en = (b_reg != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_reg, lo_reg} + prod_s;
            OP_MADDU: result = {hi_reg, lo_reg} + prod_u;
            OP_MSUB:  result = {hi_reg, lo_reg} - prod_s;
            OP_MSUBU: result = {hi_reg, lo_reg} - prod_u;
`endif
            default:  write_en = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (Start && !Req && start_code) begin
                    state_next = RUN;
                    op_next    = MDOp;
                    a_next     = A;
                    b_next     = B;
                    count_next = start_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else if (!Req && MDOp == OP_MTHI) begin
                    hi_next = A;
                end else if (!Req && MDOp == OP_MTLO) begin
                    lo_next = A;
                end
            end
            RUN: begin
                // Req is deliberately ignored here: the running op belongs to a committed instruction.
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = IDLE;
                    if (write_en) begin
                        hi_next = result[63:32];
                        lo_next = result[31:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign Busy = (state_reg == RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;
    assign MDO  = (MDOp == OP_MFHI) ? hi_reg :
                  (MDOp == OP_MFLO) ? lo_reg : 32'd0;

endmodule
